approx_error_monitor: RTL and testbench

- Synthesizable, streaming error-metric engine for approximate adders. Computes the same figures we currently derive offline in simulation, in hardware.
- Consumes paired exact/approximate N-bit sums over a valid/ready handshake.
- Accumulates error count, sum of error distance (ED), maximum ED and zero-exact count over a programmed sample window.
- Sits beside the adder-under-test in the on-chip characterisation harness. Software derives ER, MED, NMED and MRED denominators from the outputs.

---
 rtl/approx_error_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_approx_error_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// Streaming error-metric engine for approximate adders: error count, zero-exact count, sum/max ED.
// Optional macro ERRMON_SQ_EN adds sum_sq_ed (saturating sum of ED squared) with one extra stage.
module approx_error_monitor #(
   parameter int N     = 16,
   parameter int CNT_W = 32,
   parameter int ACC_W = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         exact_sum,
   input  logic [N-1:0]         approx_sum,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     zero_count,
   output logic [ACC_W-1:0]     sum_ed,
   output logic [N-1:0]         max_ed,
`ifdef ERRMON_SQ_EN
   output logic [2*N+CNT_W-1:0] sum_sq_ed,
`endif
   output logic                 acc_ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] accepted_q, accepted_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             s1_valid_q, s1_valid_d;
   logic [N-1:0]     s1_ed_q, s1_ed_d;
   logic             s1_ne_q, s1_ne_d;
   logic             s1_z_q, s1_z_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] zero_count_q, zero_count_d;
   logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
   logic [N-1:0]     max_ed_q, max_ed_d;
   logic             acc_ovf_q, acc_ovf_d;
   logic [ACC_W:0]   sum_ext;
   logic             xfer, start_ok, pipe_empty, sq_ovf;

   always_comb begin
      xfer     = in_valid & in_ready_q;
      start_ok = start & ((state_q == IDLE) | (state_q == FIN));

      state_d    = state_q;
      target_d   = target_q;
      accepted_d = accepted_q;
      case (state_q)
         IDLE, FIN: begin
            if (start) begin
               target_d   = num_samples;
               accepted_d = '0;
               state_d    = (num_samples == '0) ? FIN : RUN;
            end else if (state_q == FIN) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (xfer) begin
               accepted_d = accepted_q + CNT_W'(1);
               if (accepted_q + CNT_W'(1) == target_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pipe_empty) state_d = FIN;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == RUN);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == FIN);

      // S1: distance via full-width compare so the subtraction never wraps
      s1_valid_d = xfer;
      s1_ed_d    = (approx_sum >= exact_sum) ? (approx_sum - exact_sum) : (exact_sum - approx_sum);
      s1_ne_d    = (approx_sum != exact_sum);
      s1_z_d     = (exact_sum == '0);

      // S2: accumulate; clearing on start has priority (pipeline is empty then anyway)
      sum_ext      = {1'b0, sum_ed_q} + (ACC_W+1)'(s1_ed_q);
      err_count_d  = err_count_q;
      zero_count_d = zero_count_q;
      sum_ed_d     = sum_ed_q;
      max_ed_d     = max_ed_q;
      acc_ovf_d    = acc_ovf_q | sq_ovf;
      if (start_ok) begin
         err_count_d  = '0;
         zero_count_d = '0;
         sum_ed_d     = '0;
         max_ed_d     = '0;
         acc_ovf_d    = 1'b0;
      end else if (s1_valid_q) begin
         err_count_d  = err_count_q + CNT_W'(s1_ne_q);
         zero_count_d = zero_count_q + CNT_W'(s1_z_q);
         if (s1_ed_q > max_ed_q) max_ed_d = s1_ed_q;
         if (sum_ext[ACC_W]) begin
            sum_ed_d  = '1;
            acc_ovf_d = 1'b1;
         end else begin
            sum_ed_d = sum_ext[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         target_q     <= '0;
         accepted_q   <= '0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_ed_q      <= '0;
         s1_ne_q      <= 1'b0;
         s1_z_q       <= 1'b0;
         err_count_q  <= '0;
         zero_count_q <= '0;
         sum_ed_q     <= '0;
         max_ed_q     <= '0;
         acc_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         accepted_q   <= accepted_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         s1_valid_q   <= s1_valid_d;
         s1_ed_q      <= s1_ed_d;
         s1_ne_q      <= s1_ne_d;
         s1_z_q       <= s1_z_d;
         err_count_q  <= err_count_d;
         zero_count_q <= zero_count_d;
         sum_ed_q     <= sum_ed_d;
         max_ed_q     <= max_ed_d;
         acc_ovf_q    <= acc_ovf_d;
      end
   end

`ifdef ERRMON_SQ_EN
   localparam int SQ_W = 2*N + CNT_W;

   logic            sq_valid_q, sq_valid_d;
   logic [2*N-1:0]  sq_q, sq_d;
   logic [SQ_W-1:0] sum_sq_q, sum_sq_d;
   logic [SQ_W:0]   sum_sq_ext;

   assign pipe_empty = !s1_valid_q && !sq_valid_q;
   assign sum_sq_ed  = sum_sq_q;

   // Registered square of the S1 distance, accumulated one cycle behind the other results
   always_comb begin
      sq_valid_d = s1_valid_q;
      sq_d       = (2*N)'(s1_ed_q) * (2*N)'(s1_ed_q);
      sum_sq_ext = {1'b0, sum_sq_q} + (SQ_W+1)'(sq_q);
      sum_sq_d   = sum_sq_q;
      sq_ovf     = 1'b0;
      if (start_ok) begin
         sum_sq_d = '0;
      end else if (sq_valid_q) begin
         if (sum_sq_ext[SQ_W]) begin
            sum_sq_d = '1;
            sq_ovf   = 1'b1;
         end else begin
            sum_sq_d = sum_sq_ext[SQ_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_valid_q <= 1'b0;
         sq_q       <= '0;
         sum_sq_q   <= '0;
      end else begin
         sq_valid_q <= sq_valid_d;
         sq_q       <= sq_d;
         sum_sq_q   <= sum_sq_d;
      end
   end
`else
   assign pipe_empty = !s1_valid_q;
   assign sq_ovf     = 1'b0;
`endif

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_count  = err_count_q;
   assign zero_count = zero_count_q;
   assign sum_ed     = sum_ed_q;
   assign max_ed     = max_ed_q;
   assign acc_ovf    = acc_ovf_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: per-cycle comparison against a transaction-level model plus literal checks.
`timescale 1ns/1ps
module tb_approx_error_monitor;
   localparam int N     = 16;
   localparam int CNT_W = 32;
   localparam int ACC_W = 17;
`ifdef ERRMON_SQ_EN
   localparam int DONE_LAT = 4;
   localparam int SQ_W     = 2*N + CNT_W;
`else
   localparam int DONE_LAT = 3;
`endif
   localparam longint SUM_MAX = (longint'(1) << ACC_W) - 1;
   localparam longint NEVER   = 64'h3fff_ffff_ffff_ffff;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     exact_sum = '0;
   logic [N-1:0]     approx_sum = '0;
   logic             busy, done, acc_ovf;
   logic [CNT_W-1:0] err_count, zero_count;
   logic [ACC_W-1:0] sum_ed;
   logic [N-1:0]     max_ed;
`ifdef ERRMON_SQ_EN
   logic [SQ_W-1:0]  sum_sq_ed;
`endif

   approx_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .exact_sum(exact_sum), .approx_sum(approx_sum),
      .busy(busy), .done(done), .err_count(err_count), .zero_count(zero_count),
      .sum_ed(sum_ed), .max_ed(max_ed),
`ifdef ERRMON_SQ_EN
      .sum_sq_ed(sum_sq_ed),
`endif
      .acc_ovf(acc_ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct { longint due; longint ed; bit ne; bit z; } ent_t;
   ent_t   q_res[$];
   longint cyc = 0;
   bit     m_active;
   longint m_target, m_taken, m_done_at;
   longint e_err, e_zero, e_sum, e_max;
   bit     e_ovf, e_ready, e_busy, e_done;
`ifdef ERRMON_SQ_EN
   ent_t            q_sq[$];
   logic [SQ_W-1:0] e_sq;
`endif

   task automatic model_clear_results();
      e_err = 0; e_zero = 0; e_sum = 0; e_max = 0; e_ovf = 0;
      q_res.delete();
`ifdef ERRMON_SQ_EN
      e_sq = '0;
      q_sq.delete();
`endif
   endtask

   task automatic model_reset();
      model_clear_results();
      m_active = 0; m_target = 0; m_taken = 0; m_done_at = NEVER;
      e_ready = 0; e_busy = 0; e_done = 0;
   endtask

   // Called at the clock edge that closes cycle cyc; leaves expectations for cycle cyc+1
   task automatic model_step();
      bit     end_of_run;
      longint ed;
      end_of_run = m_active && (cyc == m_done_at);
      if (start && (!m_active || end_of_run)) begin
         model_clear_results();
         m_active  = 1;
         m_target  = longint'(num_samples);
         m_taken   = 0;
         m_done_at = (num_samples == 0) ? cyc + 1 : NEVER;
      end else begin
         if (end_of_run) m_active = 0;
         if (e_ready && in_valid) begin
            ed = (approx_sum > exact_sum) ? longint'(approx_sum) - longint'(exact_sum)
                                          : longint'(exact_sum) - longint'(approx_sum);
            q_res.push_back('{cyc + 2, ed, approx_sum != exact_sum, exact_sum == 0});
`ifdef ERRMON_SQ_EN
            q_sq.push_back('{cyc + 3, ed, 1'b0, 1'b0});
`endif
            m_taken++;
            if (m_taken == m_target) m_done_at = cyc + DONE_LAT;
         end
      end
      while (q_res.size() > 0 && q_res[0].due == cyc + 1) begin
         e_err  += q_res[0].ne;
         e_zero += q_res[0].z;
         if (q_res[0].ed > e_max) e_max = q_res[0].ed;
         e_sum += q_res[0].ed;
         if (e_sum > SUM_MAX) begin e_sum = SUM_MAX; e_ovf = 1; end
         void'(q_res.pop_front());
      end
`ifdef ERRMON_SQ_EN
      while (q_sq.size() > 0 && q_sq[0].due == cyc + 1) begin
         logic [SQ_W:0] t;
         t = {1'b0, e_sq} + (SQ_W+1)'(q_sq[0].ed * q_sq[0].ed);
         if (t[SQ_W]) begin e_sq = '1; e_ovf = 1; end
         else e_sq = t[SQ_W-1:0];
         void'(q_sq.pop_front());
      end
`endif
      e_ready = m_active && (m_taken < m_target);
      e_busy  = m_active && (cyc + 1 <= m_done_at);
      e_done  = m_active && (cyc + 1 == m_done_at);
   endtask

   // Compare process: outputs at the falling edge, model advanced at the rising edge
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("in_ready", in_ready, e_ready);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("err_count", err_count, e_err);
         chk("zero_count", zero_count, e_zero);
         chk("sum_ed", sum_ed, e_sum);
         chk("max_ed", max_ed, e_max);
         chk("acc_ovf", acc_ovf, e_ovf);
`ifdef ERRMON_SQ_EN
         chk("sum_sq_ed", sum_sq_ed, e_sq);
`endif
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   longint last_xfer;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input longint n);
      start = 1'b1;
      num_samples = CNT_W'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(input logic [N-1:0] e, input logic [N-1:0] a);
      bit ok = 0;
      exact_sum = e; approx_sum = a; in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         if (ok) last_xfer = cyc;
         tick();
      end
      in_valid = 1'b0;
      chk("xfer_accepted", ok, 1);
      $display("xfer exact=%0d approx=%0d at cycle %0d", e, a, last_xfer);
   endtask

   // Returns at the falling edge of the done cycle
   task automatic wait_done(output longint dcyc);
      bit seen = 0;
      dcyc = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; dcyc = cyc; end
      end
      chk("done_seen", seen, 1);
   endtask

   initial begin
      longint dc, sc;
      int     nx;
      bit     pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("reset_sum_ed", sum_ed, 0);
      chk("reset_busy", busy, 0);
      tick();

      // Reset in the middle of a run, then a fresh 8-sample run
      do_start(8);
      for (int i = 0; i < 3; i++) xfer(N'(i + 1), N'(i * 7));
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_sum_ed", sum_ed, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      do_start(8);
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] e;
         e = N'($urandom);
         if (i == 2) e = '0;
         xfer(e, (i % 3 == 0) ? e : N'($urandom));
      end
      wait_done(dc);
      $display("run8 done at cycle %0d sum_ed=%0d err=%0d", dc, sum_ed, err_count);
      tick();

      // Hand-computed vector set
      do_start(4);
      xfer(16'd10, 16'd10);
      xfer(16'd0, 16'd3);
      xfer(16'd100, 16'd96);
      xfer(16'd65535, 16'd0);
      wait_done(dc);
      chk("vec_err_count", err_count, 3);
      chk("vec_zero_count", zero_count, 1);
      chk("vec_sum_ed", sum_ed, 65542);
      chk("vec_max_ed", max_ed, 65535);
      chk("vec_acc_ovf", acc_ovf, 0);
      chk("vec_done_lat", dc - last_xfer, DONE_LAT);
      tick();
      @(negedge clk);
      chk("vec_done_single", done, 0);
      tick();

      // Zero-sample run
      sc = cyc;
      do_start(0);
      wait_done(dc);
      chk("zero_done_lat", dc - sc, 1);
      chk("zero_sum_ed", sum_ed, 0);
      chk("zero_max_ed", max_ed, 0);
      tick();

      // Bubbles: 6 valid cycles offered, only 5 taken
      do_start(5);
      nx = 0;
      for (int i = 0; i < 9; i++) begin
         in_valid = pat[i];
         exact_sum = N'($urandom);
         approx_sum = N'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) begin nx++; last_xfer = cyc; end
         tick();
      end
      in_valid = 1'b0;
      chk("bubble_xfers", nx, 5);
      wait_done(dc);
      chk("bubble_done_lat", dc - last_xfer, DONE_LAT);
      $display("bubble run: %0d transfers, done at cycle %0d", nx, dc);

      // Saturation, then a start during the done cycle clears the flag
      tick();
      do_start(3);
      for (int i = 0; i < 3; i++) xfer(16'd0, 16'd65535);
      wait_done(dc);
      chk("sat_sum_ed", sum_ed, 131071);
      chk("sat_acc_ovf", acc_ovf, 1);
      #1;
      start = 1'b1;
      num_samples = 1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("restart_acc_ovf", acc_ovf, 0);
      chk("restart_sum_ed", sum_ed, 0);
      chk("restart_busy", busy, 1);
      tick();
      xfer(16'd5, 16'd5);
      wait_done(dc);
      tick();

`ifdef ERRMON_SQ_EN
      do_start(2);
      xfer(16'd10, 16'd13);
      xfer(16'd20, 16'd16);
      wait_done(dc);
      chk("sq_sum", sum_sq_ed, 25);
      chk("sq_done_lat", dc - last_xfer, 4);
      tick();
`endif

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
